iob_asym_mem_lane_sequencer: RTL

//  Memory-side responder for the asymmetric converter's per-lane external memory port.

---
 rtl/iob_asym_mem_lane_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/iob_asym_mem_lane_sequencer.sv
// Serializes one wide lane-masked access onto a narrow single-port RAM, lane by lane,
// and reassembles the enabled read lanes into a wide word with a valid pulse.
module iob_asym_mem_lane_sequencer #(
    parameter int DATA_W = 32,
    parameter int R      = 4,
    parameter int ADDR_W = 3
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    output logic                                  ready_o,
    input  logic [R-1:0]                          w_en_i,
    input  logic [ADDR_W-1:0]                     w_addr_i,
    input  logic [DATA_W-1:0]                     w_data_i,
    input  logic [R-1:0]                          r_en_i,
    input  logic [ADDR_W-1:0]                     r_addr_i,
    output logic [DATA_W-1:0]                     r_data_o,
    output logic                                  r_valid_o,
    output logic                                  mem_en_o,
    output logic                                  mem_we_o,
    output logic [ADDR_W+$clog2(R)-1:0]           mem_addr_o,
    output logic [DATA_W/R-1:0]                   mem_d_o,
    input  logic [DATA_W/R-1:0]                   mem_d_i
);

    localparam int LANE_W     = DATA_W / R;
    localparam int LB         = $clog2(R);
    localparam int PHY_ADDR_W = ADDR_W + LB;

    typedef enum logic [1:0] {IDLE, WR, RD, WAIT} state_t;

    state_t                     state, state_n;
    logic [R-1:0]               w_rem, w_rem_n, r_rem, r_rem_n;
    logic [ADDR_W-1:0]          w_addr_q, w_addr_n, r_addr_q, r_addr_n;
    logic [R-1:0][LANE_W-1:0]   w_data_q, w_data_n;
    logic [LB-1:0]              lane_q, lane_n;
    logic                       mem_en_n, mem_we_n;
    logic [PHY_ADDR_W-1:0]      mem_addr_n;
    logic [LANE_W-1:0]          mem_d_n;
    logic                       r_valid_n;
    logic                       cap_valid_q;
    logic [LB-1:0]              cap_lane_q;
    logic [R-1:0][LANE_W-1:0]   r_data_q;

    logic                       request;
    logic [R-1:0]               w_mask_src, r_mask_src;
    logic [ADDR_W-1:0]          w_addr_src, r_addr_src;
    logic [R-1:0][LANE_W-1:0]   w_data_src;
    logic [LB-1:0]              w_lane, r_lane;

    function automatic logic [LB-1:0] lowest_lane(input logic [R-1:0] m);
        lowest_lane = '0;
        for (int i = R - 1; i >= 0; i--) begin
            if (m[i]) lowest_lane = LB'(i);
        end
    endfunction

    function automatic logic [R-1:0] clear_lane(input logic [R-1:0] m, input logic [LB-1:0] k);
        clear_lane = m & ~(R'(1) << k);
    endfunction

    assign request  = (|w_en_i) | (|r_en_i);
    assign ready_o  = (state == IDLE) && rst_n_i;
    assign r_data_o = r_data_q;

    // In IDLE the first lane is issued straight from the request ports so it lands in cycle 1.
    assign w_mask_src = (state == IDLE) ? w_en_i   : w_rem;
    assign r_mask_src = (state == IDLE) ? r_en_i   : r_rem;
    assign w_addr_src = (state == IDLE) ? w_addr_i : w_addr_q;
    assign r_addr_src = (state == IDLE) ? r_addr_i : r_addr_q;
    assign w_data_src = (state == IDLE) ? w_data_i : w_data_q;
    assign w_lane     = lowest_lane(w_mask_src);
    assign r_lane     = lowest_lane(r_mask_src);

    always_comb begin
        state_n    = state;
        w_rem_n    = w_rem;
        r_rem_n    = r_rem;
        w_addr_n   = w_addr_q;
        r_addr_n   = r_addr_q;
        w_data_n   = w_data_q;
        lane_n     = lane_q;
        mem_en_n   = 1'b0;
        mem_we_n   = 1'b0;
        mem_addr_n = mem_addr_o;
        mem_d_n    = mem_d_o;
        r_valid_n  = 1'b0;

        case (state)
            IDLE, WR: begin
                if (state == IDLE) begin
                    w_addr_n = w_addr_i;
                    r_addr_n = r_addr_i;
                    w_data_n = w_data_i;
                end
                if (state == WR || request) begin
                    // Writes always drain before reads so same-request reads see new data.
                    if (|w_mask_src) begin
                        state_n    = WR;
                        lane_n     = w_lane;
                        mem_en_n   = 1'b1;
                        mem_we_n   = 1'b1;
                        mem_addr_n = {w_addr_src, w_lane};
                        mem_d_n    = w_data_src[w_lane];
                        w_rem_n    = clear_lane(w_mask_src, w_lane);
                        r_rem_n    = r_mask_src;
                    end else if (|r_mask_src) begin
                        state_n    = RD;
                        lane_n     = r_lane;
                        mem_en_n   = 1'b1;
                        mem_addr_n = {r_addr_src, r_lane};
                        w_rem_n    = '0;
                        r_rem_n    = clear_lane(r_mask_src, r_lane);
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            RD: begin
                if (|r_rem) begin
                    lane_n     = r_lane;
                    mem_en_n   = 1'b1;
                    mem_addr_n = {r_addr_q, r_lane};
                    r_rem_n    = clear_lane(r_rem, r_lane);
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                state_n   = IDLE;
                r_valid_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Read data for the lane issued last cycle is on mem_d_i now; cap_* remembers which lane.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            w_rem       <= '0;
            r_rem       <= '0;
            w_addr_q    <= '0;
            r_addr_q    <= '0;
            w_data_q    <= '0;
            lane_q      <= '0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_d_o     <= '0;
            r_valid_o   <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_lane_q  <= '0;
            r_data_q    <= '0;
        end else begin
            state       <= state_n;
            w_rem       <= w_rem_n;
            r_rem       <= r_rem_n;
            w_addr_q    <= w_addr_n;
            r_addr_q    <= r_addr_n;
            w_data_q    <= w_data_n;
            lane_q      <= lane_n;
            mem_en_o    <= mem_en_n;
            mem_we_o    <= mem_we_n;
            mem_addr_o  <= mem_addr_n;
            mem_d_o     <= mem_d_n;
            r_valid_o   <= r_valid_n;
            cap_valid_q <= (state == RD);
            cap_lane_q  <= lane_q;
            if (cap_valid_q) r_data_q[cap_lane_q] <= mem_d_i;
        end
    end

endmodule
